instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_isa_pkg.sv | 49 ++++
 rtl/instr_enc_core.sv | 36 +++
 rtl/instr_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA definitions: operation enum, opcodes, funct codes and field packers.
// Used by the encoder here and by the decoder elsewhere in the codebase.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_J    = 4'd10,
    OP_JAL  = 4'd11
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_enc_core.sv
// Combinational field packer: operation plus operand fields -> 32-bit instruction word.
// Illegal operations produce an all-zero word (NOP) and raise the illegal flag.
module instr_enc_core
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = pack_r(rs, rt, rd, FUNCT_ADD);
      OP_SUB:  word = pack_r(rs, rt, rd, FUNCT_SUB);
      OP_AND:  word = pack_r(rs, rt, rd, FUNCT_AND);
      OP_OR:   word = pack_r(rs, rt, rd, FUNCT_OR);
      OP_SLT:  word = pack_r(rs, rt, rd, FUNCT_SLT);
      OP_ADDI: word = pack_i(OPC_ADDI, rs, rt, imm);
      OP_LW:   word = pack_i(OPC_LW, rs, rt, imm);
      OP_SW:   word = pack_i(OPC_SW, rs, rt, imm);
      OP_BEQ:  word = pack_i(OPC_BEQ, rs, rt, imm);
      OP_BNE:  word = pack_i(OPC_BNE, rs, rt, imm);
      OP_J:    word = pack_j(OPC_J, target);
      OP_JAL:  word = pack_j(OPC_JAL, target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests and writes packed words to instruction memory.
// Optional macro INSTR_ENCODER_ILLEGAL_TRAP_EN turns illegal ops into a sticky error with no write.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  output logic [15:0] count_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, READY, WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, data_q;
  logic [15:0] count_q;
  logic        err_q;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        ack, accept, emit;
  logic        unused_base;

  assign unused_base = ^base_addr_i[1:0];

  instr_enc_core u_core (
    .op      (op_i),
    .rs      (rs_i),
    .rt      (rt_i),
    .rd      (rd_i),
    .imm     (imm_i),
    .target  (target_i),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

`ifdef INSTR_ENCODER_ILLEGAL_TRAP_EN
  assign emit = ~enc_illegal;
`else
  logic unused_illegal;
  assign unused_illegal = enc_illegal;
  assign emit = 1'b1;
`endif

  assign ack        = (state_q == WRITE) & mem_ack_i;
  assign in_ready_o = ~start_i & ((state_q == READY) | ack);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = READY;
    end else begin
      case (state_q)
        READY:   if (accept && emit) state_d = WRITE;
        // Ack with a new request chains straight into the next write.
        WRITE:   if (ack) state_d = (accept && emit) ? WRITE : READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        addr_q  <= {base_addr_i[31:2], 2'b00};
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (ack) begin
          addr_q <= addr_q + 32'd4;
          if (count_q != '1) count_q <= count_q + 16'd1;
        end
        if (accept && emit) data_q <= enc_word;
        if (accept && !emit) err_q <= 1'b1;
      end
    end
  end

  assign mem_we_o   = (state_q == WRITE);
  assign busy_o     = (state_q == WRITE);
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign count_o    = count_q;
  assign err_o      = err_q;

endmodule
